// File: rtl/fft_iter.sv
// fft_iter: iterative in-place radix-2 DIT FFT, one butterfly per cycle, streaming I/O.
// Define FFT_STAGE_SCALE_EN to halve every butterfly output (overall gain 1/N).
module fft_iter #(
  parameter int N   = 8,
  parameter int DW  = 16,
  parameter int TWF = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_imag,
  output logic                 out_last,
  output logic                 busy,
  output logic                 ovf
);
  localparam int  LG = $clog2(N);
  localparam int  BW = LG - 1;
  localparam int  CW = LG + 1;
  localparam int  TW = TWF + 2;
  localparam int  PW = DW + TW + 1;
  localparam int  YW = DW + 2;
  localparam real PI = 3.14159265358979323846;
  localparam logic signed [PW-1:0] RND   = PW'(1) <<< (TWF - 1);
  localparam logic signed [YW-1:0] Y_MAX = YW'((2 ** (DW - 1)) - 1);
  localparam logic signed [YW-1:0] Y_MIN = -Y_MAX - YW'(1);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_UNLOAD} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LG-1:0]        stage_q, stage_d;
  logic [BW-1:0]        bfly_q, bfly_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic signed [DW-1:0] out_real_q, out_real_d;
  logic signed [DW-1:0] out_imag_q, out_imag_d;

  logic signed [DW-1:0] mem_re_q [N];
  logic signed [DW-1:0] mem_im_q [N];
  logic signed [TW-1:0] tw_re [N/2];
  logic signed [TW-1:0] tw_im [N/2];

  logic [BW-1:0]        mask, tw_lo, tw_idx;
  logic [LG-1:0]        addr_a, addr_b, load_addr;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [PW-1:0] p_re, p_im;
  logic signed [YW-1:0] t_re, t_im, y1_re, y1_im, y2_re, y2_im;
  logic signed [DW-1:0] r1_re, r1_im, r2_re, r2_im;
  logic                 clip, load_we, calc_we;

  // Twiddle ROM: W_k = exp(-j*2*pi*k/N), rounded to nearest at elaboration.
  for (genvar gi = 0; gi < N / 2; gi++) begin : g_tw
    localparam real ANG = 2.0 * PI * gi / N;
    localparam real CR  = $cos(ANG) * (2.0 ** TWF);
    localparam real SR  = -$sin(ANG) * (2.0 ** TWF);
    localparam int  CI  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
    localparam int  SI  = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
    assign tw_re[gi] = TW'(CI);
    assign tw_im[gi] = TW'(SI);
  end

  function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] v);
    logic [LG-1:0] r;
    for (int b = 0; b < LG; b++) r[b] = v[LG-1-b];
    return r;
  endfunction

  function automatic logic clipped(input logic signed [YW-1:0] y);
    return (y > Y_MAX) || (y < Y_MIN);
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [YW-1:0] y);
    if (y > Y_MAX) return DW'(Y_MAX);
    if (y < Y_MIN) return DW'(Y_MIN);
    return DW'(y);
  endfunction

  assign load_addr = bitrev(cnt_q[LG-1:0]);

  // Butterfly j of stage s pairs (a, a+2^s): a is j with a zero inserted at bit s.
  always_comb begin
    mask   = (BW'(1) << stage_q) - BW'(1);
    tw_lo  = bfly_q & mask;
    addr_a = {bfly_q & ~mask, 1'b0} | {1'b0, tw_lo};
    addr_b = addr_a | (LG'(1) << stage_q);
    tw_idx = tw_lo << (LG - 1 - stage_q);
    a_re   = mem_re_q[addr_a];
    a_im   = mem_im_q[addr_a];
    b_re   = mem_re_q[addr_b];
    b_im   = mem_im_q[addr_b];
    w_re   = tw_re[tw_idx];
    w_im   = tw_im[tw_idx];
    p_re   = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    p_im   = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    t_re   = YW'((p_re + RND) >>> TWF);
    t_im   = YW'((p_im + RND) >>> TWF);
    y1_re  = YW'(a_re) + t_re;
    y1_im  = YW'(a_im) + t_im;
    y2_re  = YW'(a_re) - t_re;
    y2_im  = YW'(a_im) - t_im;
`ifdef FFT_STAGE_SCALE_EN
    y1_re  = (y1_re + YW'(1)) >>> 1;
    y1_im  = (y1_im + YW'(1)) >>> 1;
    y2_re  = (y2_re + YW'(1)) >>> 1;
    y2_im  = (y2_im + YW'(1)) >>> 1;
`else
`endif
    r1_re  = sat(y1_re);
    r1_im  = sat(y1_im);
    r2_re  = sat(y2_re);
    r2_im  = sat(y2_im);
    clip   = clipped(y1_re) | clipped(y1_im) | clipped(y2_re) | clipped(y2_im);
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    bfly_d      = bfly_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    load_we     = 1'b0;
    calc_we     = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          load_we = 1'b1;
          if (cnt_q == '0) ovf_d = 1'b0;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CALC: begin
        calc_we = 1'b1;
        if (clip) ovf_d = 1'b1;
        if (bfly_q == BW'(N / 2 - 1)) begin
          bfly_d = '0;
          if (stage_q == LG'(LG - 1)) begin
            stage_d = '0;
            state_d = S_UNLOAD;
          end else begin
            stage_d = stage_q + LG'(1);
          end
        end else begin
          bfly_d = bfly_q + BW'(1);
        end
      end
      S_UNLOAD: begin
        // Registered output stage: fetch the next bin whenever the slot is empty or draining.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            cnt_d      = '0;
            state_d    = S_LOAD;
          end
        end
        if (cnt_q < CW'(N) && (!out_valid_q || out_ready)) begin
          out_valid_d = 1'b1;
          out_real_d  = mem_re_q[cnt_q[LG-1:0]];
          out_imag_d  = mem_im_q[cnt_q[LG-1:0]];
          out_last_d  = (cnt_q == CW'(N - 1));
          cnt_d       = cnt_q + CW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      stage_q     <= '0;
      bfly_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
    end
  end

  // NOTE: the sample arrays are cleared on reset, which forces them into flops rather than RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int idx = 0; idx < N; idx++) begin
        mem_re_q[idx] <= '0;
        mem_im_q[idx] <= '0;
      end
    end else if (load_we) begin
      mem_re_q[load_addr] <= in_real;
      mem_im_q[load_addr] <= in_imag;
    end else if (calc_we) begin
      mem_re_q[addr_a] <= r1_re;
      mem_im_q[addr_a] <= r1_im;
      mem_re_q[addr_b] <= r2_re;
      mem_im_q[addr_b] <= r2_im;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_CALC) || (state_q == S_UNLOAD);
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;

endmodule

// File: tb/tb_fft_iter.sv
// tb_fft_iter: directed and randomized frames for fft_iter (N=8, DW=16, TWF=8),
// checked against a stage-by-stage integer FFT model built from the transform rules.
module tb_fft_iter;
  localparam int  N     = 8;
  localparam int  DW    = 16;
  localparam int  TWF   = 8;
  localparam int  LG    = 3;
  localparam int  LAT   = (N / 2) * LG + 1;
  localparam real PI    = 3.14159265358979323846;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, out_valid, out_ready, out_last, busy, ovf;
  logic signed [DW-1:0] in_real, in_imag, out_real, out_imag;

  always #5 clk = ~clk;

  fft_iter #(.N(N), .DW(DW), .TWF(TWF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_last(out_last), .busy(busy), .ovf(ovf)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int xr[N], xi[N], er[N], ei[N], gr[N], gi[N];
  bit eovf;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    tests_run++;
    assert (obs >= exp - tol && obs <= exp + tol) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  function automatic longint rnd_tw(input real v);
    return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
  endfunction

  task automatic narrow(input longint y, output longint v);
    v = y;
`ifdef FFT_STAGE_SCALE_EN
    v = (v + 1) >>> 1;
`endif
    if (v > MAXV) begin v = MAXV; eovf = 1'b1; end
    else if (v < MINV) begin v = MINV; eovf = 1'b1; end
  endtask

  // Reference: bit-reversed load, then log2(N) in-place stages of rounded, saturated butterflies.
  task automatic run_model();
    longint ar[N], ai[N];
    eovf = 1'b0;
    for (int n = 0; n < N; n++) begin
      int r = 0;
      for (int b = 0; b < LG; b++) if (((n >> b) & 1) == 1) r |= 1 << (LG - 1 - b);
      ar[r] = xr[n];
      ai[r] = xi[n];
    end
    for (int s = 0; s < LG; s++) begin
      int half = 1 << s;
      for (int g = 0; g < N; g += 2 * half) begin
        for (int m = 0; m < half; m++) begin
          int     a   = g + m;
          int     b   = g + m + half;
          int     k   = m * N / (2 * half);
          real    ang = 2.0 * PI * k / N;
          longint wr  = rnd_tw($cos(ang) * 256.0);
          longint wi  = rnd_tw(-$sin(ang) * 256.0);
          longint tr  = (ar[b] * wr - ai[b] * wi + 128) >>> TWF;
          longint ti  = (ar[b] * wi + ai[b] * wr + 128) >>> TWF;
          longint ar0 = ar[a];
          longint ai0 = ai[a];
          narrow(ar0 + tr, ar[a]);
          narrow(ai0 + ti, ai[a]);
          narrow(ar0 - tr, ar[b]);
          narrow(ai0 - ti, ai[b]);
        end
      end
    end
    for (int n = 0; n < N; n++) begin
      er[n] = int'(ar[n]);
      ei[n] = int'(ai[n]);
    end
  endtask

  task automatic clear_x();
    for (int n = 0; n < N; n++) begin xr[n] = 0; xi[n] = 0; end
  endtask

  task automatic set_random(input int amp);
    for (int n = 0; n < N; n++) begin
      xr[n] = int'($urandom_range(0, 2 * amp)) - amp;
      xi[n] = int'($urandom_range(0, 2 * amp)) - amp;
    end
  endtask

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic send_frame();
    for (int n = 0; n < N; n++) begin
      int guard = 0;
      in_valid = 1'b1;
      in_real  = DW'(xr[n]);
      in_imag  = DW'(xi[n]);
      while (!in_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!in_ready) check("send_in_ready_wait", in_ready, 1);
      @(posedge clk); #1;
      if (n == 0) check("ovf_clear_first_beat", ovf, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int edges = 0;
    check({tag, "_busy_calc"}, busy, 1);
    while (!out_valid && edges < 100) begin
      check({tag, "_in_ready_calc"}, in_ready, 0);
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, edges, LAT);
  endtask

  // mode 0: out_ready always 1; mode 1: pattern 1,0,0 repeating; mode 2: random.
  task automatic recv_frame(input string tag, input int mode);
    int idx = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic signed [DW-1:0] hr = '0, hi = '0;
    logic hl = 1'b0;
    while (idx < N && cyc < 500) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (held) begin
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_real"}, out_real, hr);
        check({tag, "_hold_imag"}, out_imag, hi);
        check({tag, "_hold_last"}, out_last, hl);
        held = 1'b0;
      end
      if (out_valid) begin
        if (out_ready) begin
          gr[idx] = out_real;
          gi[idx] = out_imag;
          check($sformatf("%s_last_bin%0d", tag, idx), out_last, (idx == N - 1));
          idx++;
        end else begin
          hr   = out_real;
          hi   = out_imag;
          hl   = out_last;
          held = 1'b1;
        end
      end
      check({tag, "_in_ready_unload"}, in_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (idx != N) check({tag, "_bins_received"}, idx, N);
    check({tag, "_in_ready_after_last"}, in_ready, 1);
    check({tag, "_out_valid_after_last"}, out_valid, 0);
  endtask

  task automatic run_frame(input string tag, input int mode);
    send_frame();
    wait_out(tag);
    recv_frame(tag, mode);
  endtask

  task automatic compare_model(input string tag);
    for (int n = 0; n < N; n++) begin
      check($sformatf("%s_re%0d", tag, n), gr[n], er[n]);
      check($sformatf("%s_im%0d", tag, n), gi[n], ei[n]);
    end
    check({tag, "_ovf"}, ovf, eovf);
  endtask

  task automatic check_impulse(input string tag);
`ifdef FFT_STAGE_SCALE_EN
    int imp = 13;
`else
    int imp = 100;
`endif
    for (int n = 0; n < N; n++) begin
      check($sformatf("%s_re%0d", tag, n), gr[n], imp);
      check($sformatf("%s_im%0d", tag, n), gi[n], 0);
    end
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
`ifdef FFT_STAGE_SCALE_EN
    int dc0 = 64;
`else
    int dc0 = 512;
`endif
    rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_real", out_real, 0);
    check("rst_out_imag", out_imag, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Impulse
    clear_x();
    xr[0] = 100;
    run_frame("impulse", 0);
    check_impulse("impulse");

    // DC
    for (int n = 0; n < N; n++) xr[n] = 64;
    for (int n = 0; n < N; n++) xi[n] = 0;
    run_frame("dc", 0);
    for (int n = 0; n < N; n++) begin
      check($sformatf("dc_re%0d", n), gr[n], (n == 0) ? dc0 : 0);
      check($sformatf("dc_im%0d", n), gi[n], 0);
    end

`ifndef FFT_STAGE_SCALE_EN
    // Cosine at bin 1
    xr = '{256, 181, 0, -181, -256, -181, 0, 181};
    for (int n = 0; n < N; n++) xi[n] = 0;
    run_frame("cosine", 0);
    for (int n = 0; n < N; n++) begin
      check_near($sformatf("cosine_re%0d", n), gr[n], (n == 1 || n == 7) ? 1024 : 0, 2);
      check_near($sformatf("cosine_im%0d", n), gi[n], 0, 2);
    end
    check("cosine_ovf", ovf, 0);

    // Saturation
    for (int n = 0; n < N; n++) begin xr[n] = 32767; xi[n] = 0; end
    run_model();
    run_frame("sat", 0);
    check("sat_x0", gr[0], 32767);
    check("sat_ovf", ovf, 1);
    compare_model("sat");
`endif

    // Backpressure with pattern 1,0,0 on a random frame
    set_random(3000);
    run_model();
    run_frame("bp", 1);
    compare_model("bp");

    // Random frames with random backpressure, including a full-scale one
    set_random(1000);
    run_model();
    run_frame("rnd_small", 2);
    compare_model("rnd_small");
    set_random(12000);
    run_model();
    run_frame("rnd_mid", 2);
    compare_model("rnd_mid");
    set_random(32000);
    run_model();
    run_frame("rnd_full", 2);
    compare_model("rnd_full");

    // Reset during the 5th CALC cycle
    clear_x();
    xr[0] = 100;
    send_frame();
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("midcalc_busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("midcalc_in_ready", in_ready, 1);
    check("midcalc_out_valid", out_valid, 0);
    check("midcalc_out_last", out_last, 0);
    check("midcalc_busy", busy, 0);
    check("midcalc_ovf", ovf, 0);
    check("midcalc_out_real", out_real, 0);
    check("midcalc_out_imag", out_imag, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    out_ready = 1'b1;
    repeat (20) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("midcalc_no_out_valid", seen, 0);
    check("midcalc_idle_in_ready", in_ready, 1);
    run_frame("post_rst", 0);
    check_impulse("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fft_iter.md
# fft_iter

Parametrised, in-place, radix-2 decimation-in-time FFT engine. Successor to the fixed 8-point parallel FFT: it trades eight parallel lanes for one time-multiplexed butterfly, and generalises point count, sample width and twiddle precision. Samples stream in and out one complex sample per beat over valid/ready handshakes. The block sits between the sample front end and the spectral post-processing stage.

## Interface

Parameters
- `N`, default 8: transform size. Power of two, 4..256.
- `DW`, default 16: signed real and imaginary sample width.
- `TWF`, default 8: twiddle fractional bits. 1.0 is represented as 2^TWF (256).

Ports
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: an input sample is presented.
- `in_ready`, output, 1: the block accepts an input sample. A beat transfers when in_valid and in_ready are both high.
- `in_real` / `in_imag`, input, DW each: signed input sample, in natural order.
- `out_valid`, output, 1: an output bin is presented.
- `out_ready`, input, 1: the downstream accepts the output bin.
- `out_real` / `out_imag`, output, DW each: signed output bin, in natural order.
- `out_last`, output, 1: high together with bin N-1.
- `busy`, output, 1: high in CALC and UNLOAD.
- `ovf`, output, 1: sticky flag. Set when any butterfly result saturates.

## Operation

- The block stores one frame in internal arrays of 2×N×DW bits.
- State machine:
  - LOAD → CALC after the N-th input beat.
  - CALC → UNLOAD after the last butterfly.
  - UNLOAD → LOAD after bin N-1 transfers.
- LOAD:
  - in_ready is 1.
  - Sample n is written to address bitrev(n), with log2(N) bits reversed.
  - The input counter increments on each beat.
  - The first beat of a frame clears ovf.
- CALC:
  - Exactly one butterfly per cycle.
  - Stages s = 0..log2(N)-1 run in order, with N/2 butterflies per stage.
  - Butterfly pairs are addresses (a, a+2^s).
  - Twiddle index: k = (a mod 2^s)·N/2^(s+1).
  - Operands are read combinationally from the arrays, and both results are written back on the same edge.
  - There are no bubbles between stages.
- Butterfly arithmetic:
  - t = B·W_k, with W_k = exp(-j2πk/N).
  - Each product component is computed at full width, then rounded: (p + 2^(TWF-1)) >>> TWF.
  - y1 = A + t, y2 = A − t, computed at DW+2 bits.
  - The result is then narrowed as set under Configuration.
- Twiddle ROM:
  - N/2 entries: round(cos·2^TWF) and round(−sin·2^TWF).
  - Built at elaboration.
  - For N=8, TWF=8: (256,0), (181,−181), (0,−256), (−181,−181).
- UNLOAD:
  - Bins are presented from address 0 to N-1.
  - out_real, out_imag and out_last hold stable while out_valid=1 and out_ready=0.
- in_valid is ignored while in_ready=0.

## Timing

- Reset values:
  - state LOAD, all counters 0.
  - in_ready=1.
  - out_valid=0, out_last=0, busy=0, ovf=0.
  - out_real=0, out_imag=0.
  - Sample arrays cleared.
- Reset mid-frame, in any state: the frame is abandoned. in_ready returns to 1 immediately on assertion. Nothing is emitted.
- CALC length is C = (N/2)·log2(N) cycles, which is 12 for N=8.
- out_valid rises C+1 edges after the edge that accepts the last input: 13 cycles for N=8.
- in_ready falls on the same edge that accepts the N-th input beat.
- With out_ready held at 1, one bin transfers per cycle, so the frame unloads in N cycles.
- in_ready rises on the edge that transfers bin N-1. The next frame's first beat can transfer on the following edge.
- Throughput with no stalls is one frame per 2N + C + 1 cycles.
- ovf is registered on the cycle after the saturating butterfly, then holds.

## Configuration

- Macro: `FFT_STAGE_SCALE_EN`.
- Defined:
  - Every butterfly output is halved with round-half-up: (y + 1) >>> 1.
  - The result is then saturated to DW bits.
  - Overall gain is 1/N. ovf should never set for in-range inputs.
- Not defined:
  - No scaling. Overall gain is N.
  - y is saturated to [−2^(DW−1), 2^(DW−1)−1], and ovf is set on any clip.

## Test plan

All scenarios use N=8, DW=16, TWF=8 unless stated.

- Impulse: x[0]=100+0j, all other inputs 0.
  - Unscaled build: all 8 bins are 100+0j.
  - `FFT_STAGE_SCALE_EN` build: all 8 bins are 13+0j.
- DC: all inputs 64+0j.
  - Unscaled build: X[0]=512, X[1..7]=0.
  - Scaled build: X[0]=64, X[1..7]=0.
- Cosine: x[n] = 256, 181, 0, −181, −256, −181, 0, 181 (unscaled build).
  - X[1] and X[7] are 1024±2.
  - All other bins are within ±2 of 0.
  - ovf=0.
- Saturation: all inputs 32767+0j (unscaled build).
  - X[0]=32767 and ovf=1.
  - The next frame's first beat clears ovf.
- Backpressure and latency:
  - out_valid rises exactly 13 cycles after the last input accept.
  - Toggle out_ready with pattern 1,0,0,1,… The bins are still emitted in order 0..7, each held stable while stalled, with out_last only on bin 7.
  - in_ready is 0 throughout CALC and UNLOAD.
- Reset mid-CALC: assert rst in the 5th CALC cycle.
  - All outputs return to their reset values.
  - No out_valid appears.
  - A fresh impulse frame then produces the correct result with the correct latency.
